alu_seq: RTL

//  Registered, multi-cycle successor to the single-cycle ALU of the CPU datapath. Executes the

---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/alu_muldiv_iter.sv | 74 +++++++
 rtl/alu_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU and its iterative mul/div unit.
package alu_seq_pkg;

    localparam logic [3:0] OP_PASS = 4'h0;
    localparam logic [3:0] OP_NOT  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_NEGA = 4'h6;
    localparam logic [3:0] OP_NEGB = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_SRA  = 4'hB;
    localparam logic [3:0] OP_MULU = 4'hC;
    localparam logic [3:0] OP_DIVU = 4'hD;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    // Divide by zero completes in one cycle, so it never occupies the iterative unit.
    function automatic logic is_multi(input logic [3:0] op, input logic b_nonzero);
        return (op == OP_MULU) || ((op == OP_DIVU) && b_nonzero);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step per clock,
// WIDTH steps per operation; last_o flags the step whose result is final.
module alu_muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             div_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    logic             div_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, opd_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // hi:lo is the running product (mul) or remainder:quotient-shift register (div).
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, opd_q};
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (div_q) begin
            if (!diff[WIDTH]) begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign last_o = step_i && (cnt_q == '0);
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= 1'b0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            opd_q <= '0;
        end else if (start_i) begin
            div_q <= div_i;
            cnt_q <= SHW'(WIDTH - 1);
            hi_q  <= '0;
            lo_q  <= a_i;
            opd_q <= b_i;
        end else if (step_i) begin
            cnt_q <= cnt_q - SHW'(1);
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: single-cycle ops complete at the accepting edge, MULU/DIVU
// run on the iterative unit. States: IDLE | accept ops ; MUL | multiply steps ; DIV | divide steps
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output logic [WIDTH-1:0] y_hi_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o,
    output logic             negative_o,
    output logic             div_by_zero_o
);

    localparam int               MSB   = WIDTH - 1;
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] y_q, y_d, y_hi_q, y_hi_d;
    logic             carry_q, carry_d, ovf_q, ovf_d;
    logic             zero_q, zero_d, neg_q, neg_d, dbz_q, dbz_d;

    logic                    md_start, md_step, md_last;
    logic [WIDTH-1:0]        md_lo, md_hi;
    logic [SHW-1:0]          sh;
    logic [WIDTH:0]          add_ext, sub_ext, shl_ext, shr_ext, sra_ext;
    logic signed [WIDTH:0]   sra_src;
    logic [WIDTH-1:0]        neg_a, neg_b;
    logic [WIDTH-1:0]        s_y, s_hi;
    logic                    s_c, s_v, s_dbz;

    assign md_start = (state_q == ST_IDLE) && start_i && is_multi(op_i, b_i != '0);
    assign md_step  = (state_q != ST_IDLE);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (md_start),
        .div_i   (op_i == OP_DIVU),
        .step_i  (md_step),
        .a_i     (a_i),
        .b_i     (b_i),
        .last_o  (md_last),
        .lo_o    (md_lo),
        .hi_o    (md_hi)
    );

    // Shifts carry one guard bit so the last bit shifted out falls into it (0 for amount 0).
    always_comb begin
        sh      = b_i[SHW-1:0];
        add_ext = {1'b0, a_i} + {1'b0, b_i};
        sub_ext = {1'b0, a_i} - {1'b0, b_i};
        shl_ext = {1'b0, a_i} << sh;
        shr_ext = {a_i, 1'b0} >> sh;
        sra_src = {a_i, 1'b0};
        sra_ext = sra_src >>> sh;
        neg_a   = ~a_i + ONE;
        neg_b   = ~b_i + ONE;
    end

    always_comb begin
        s_y   = a_i;
        s_hi  = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        s_dbz = 1'b0;
        case (op_i)
            OP_PASS: s_y = a_i;
            OP_NOT:  s_y = ~a_i;
            OP_ADD: begin
                {s_c, s_y} = add_ext;
                s_v = (a_i[MSB] == b_i[MSB]) && (add_ext[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                {s_c, s_y} = sub_ext;
                s_v = (a_i[MSB] != b_i[MSB]) && (sub_ext[MSB] != a_i[MSB]);
            end
            OP_AND:  s_y = a_i & b_i;
            OP_OR:   s_y = a_i | b_i;
            OP_XOR:  s_y = a_i ^ b_i;
            OP_NEGA: begin
                s_y = neg_a;
                s_c = (a_i != '0);
                s_v = (a_i == MIN_S);
            end
            OP_NEGB: begin
                s_y = neg_b;
                s_c = (b_i != '0);
                s_v = (b_i == MIN_S);
            end
            OP_SHL:  {s_c, s_y} = shl_ext;
            OP_SHR:  {s_y, s_c} = shr_ext;
            OP_SRA:  {s_y, s_c} = sra_ext;
            OP_DIVU: begin
                s_y   = '1;
                s_hi  = a_i;
                s_dbz = 1'b1;
            end
            default: s_y = a_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        y_d     = y_q;
        y_hi_d  = y_hi_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (md_start) begin
                    state_d = (op_i == OP_MULU) ? ST_MUL : ST_DIV;
                end else if (start_i) begin
                    done_d  = 1'b1;
                    y_d     = s_y;
                    y_hi_d  = s_hi;
                    carry_d = s_c;
                    ovf_d   = s_v;
                    zero_d  = (s_y == '0);
                    neg_d   = s_y[MSB];
                    dbz_d   = s_dbz;
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    y_d     = md_lo;
                    y_hi_d  = md_hi;
                    carry_d = (state_q == ST_MUL) && (md_hi != '0);
                    ovf_d   = 1'b0;
                    zero_d  = (state_q == ST_MUL) ? ({md_hi, md_lo} == '0) : (md_lo == '0);
                    neg_d   = md_lo[MSB];
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            y_q     <= '0;
            y_hi_q  <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            y_q     <= y_d;
            y_hi_q  <= y_hi_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            dbz_q   <= dbz_d;
        end
    end

    assign y_o           = y_q;
    assign y_hi_o        = y_hi_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign carry_o       = carry_q;
    assign overflow_o    = ovf_q;
    assign zero_o        = zero_q;
    assign negative_o    = neg_q;
    assign div_by_zero_o = dbz_q;

endmodule
